// File: rtl/driver_pipe.sv
// Operand driver: picks an operand pair (random / directed / corner sweep / hold) for the DUT
// and forwards a LATENCY-delayed copy to the monitor. Define DRIVER_PARITY_EN for o_delayed_parity.
module driver_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_dut,
  input  logic             reset_dut,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_rand_a,
  input  logic [WIDTH-1:0] i_rand_b,
  input  logic [WIDTH-1:0] i_dir_a,
  input  logic [WIDTH-1:0] i_dir_b,
  output logic [WIDTH-1:0] o_drive_a,
  output logic [WIDTH-1:0] o_drive_b,
  output logic             o_drive_valid,
  output logic [WIDTH-1:0] o_drive_delayed_a,
  output logic [WIDTH-1:0] o_drive_delayed_b,
  output logic             o_delayed_valid,
`ifdef DRIVER_PARITY_EN
  output logic             o_delayed_parity,
`endif
  output logic [CNT_W-1:0] o_vec_count
);

  localparam logic [1:0] MODE_RAND  = 2'b00;
  localparam logic [1:0] MODE_DIR   = 2'b01;
  localparam logic [1:0] MODE_SWEEP = 2'b10;
`ifdef DRIVER_PARITY_EN
  localparam int DW = 2*WIDTH + 2;
`else
  localparam int DW = 2*WIDTH + 1;
`endif

  logic [3:0]       idx_reg;
  logic [3:0]       idx_eff;
  logic [WIDTH-1:0] last_a_reg;
  logic [WIDTH-1:0] last_b_reg;
  logic [WIDTH-1:0] hold_a;
  logic [WIDTH-1:0] hold_b;
  logic [CNT_W-1:0] count_reg;
  logic [DW-1:0]    entry_in;
  logic [DW-1:0]    stage_reg [LATENCY];

  function automatic logic [WIDTH-1:0] corner(input logic [1:0] sel);
    logic [WIDTH-1:0] val;
    case (sel)
      2'd0:    val = '0;
      2'd1:    val = {{(WIDTH-1){1'b0}}, 1'b1};
      2'd2:    val = '1;
      default: val = {1'b1, {(WIDTH-1){1'b0}}};
    endcase
    return val;
  endfunction

  // Reset is made visible to the mux immediately so sweep/hold show their cleared state during reset.
  always_comb begin
    idx_eff = reset_dut ? 4'd0 : idx_reg;
    hold_a  = reset_dut ? '0 : last_a_reg;
    hold_b  = reset_dut ? '0 : last_b_reg;
    o_drive_a = hold_a;
    o_drive_b = hold_b;
    case (i_mode)
      MODE_RAND: begin
        o_drive_a = i_rand_a;
        o_drive_b = i_rand_b;
      end
      MODE_DIR: begin
        o_drive_a = i_dir_a;
        o_drive_b = i_dir_b;
      end
      MODE_SWEEP: begin
        o_drive_a = corner(idx_eff[3:2]);
        o_drive_b = corner(idx_eff[1:0]);
      end
      default: ;
    endcase
  end

  assign o_drive_valid = i_en & ~reset_dut;

  always_ff @(posedge clk_dut) begin
    if (reset_dut) begin
      idx_reg    <= 4'd0;
      last_a_reg <= '0;
      last_b_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (i_mode != MODE_SWEEP)
        idx_reg <= 4'd0;
      else if (i_en)
        idx_reg <= idx_reg + 4'd1;
      if (i_en && (i_mode != 2'b11)) begin
        last_a_reg <= o_drive_a;
        last_b_reg <= o_drive_b;
      end
      if (i_en && (count_reg != '1))
        count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign o_vec_count = count_reg;

`ifdef DRIVER_PARITY_EN
  assign entry_in = {o_drive_a, o_drive_b, o_drive_valid, ^{o_drive_a, o_drive_b}};
  assign {o_drive_delayed_a, o_drive_delayed_b, o_delayed_valid, o_delayed_parity} = stage_reg[LATENCY-1];
`else
  assign entry_in = {o_drive_a, o_drive_b, o_drive_valid};
  assign {o_drive_delayed_a, o_drive_delayed_b, o_delayed_valid} = stage_reg[LATENCY-1];
`endif

  // Free-running shift: stalls enter as valid=0 bubbles, mirroring the DUT pipeline.
  always_ff @(posedge clk_dut) begin
    if (reset_dut) begin
      for (int i = 0; i < LATENCY; i++)
        stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= entry_in;
      for (int i = 1; i < LATENCY; i++)
        stage_reg[i] <= stage_reg[i-1];
    end
  end

endmodule

// File: tb/tb_driver_pipe.sv
// Bench for driver_pipe: two instances (LATENCY=3/CNT_W=16 and LATENCY=1/CNT_W=4) on shared
// stimulus, checked each cycle against a queue-based reference model.
module tb_driver_pipe;
  localparam int W  = 32;
  localparam int LA = 3;
  localparam int LB = 1;
  localparam int CA = 16;
  localparam int CB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en;
  logic [1:0]   mode;
  logic [W-1:0] ra, rb, da, db;

  logic [W-1:0]  a_drv_a, a_drv_b, a_del_a, a_del_b;
  logic          a_drv_v, a_del_v;
  logic [CA-1:0] a_cnt;
  logic [W-1:0]  b_drv_a, b_drv_b, b_del_a, b_del_b;
  logic          b_drv_v, b_del_v;
  logic [CB-1:0] b_cnt;
`ifdef DRIVER_PARITY_EN
  logic a_del_p, b_del_p;
`endif

  driver_pipe #(.WIDTH(W), .LATENCY(LA), .CNT_W(CA)) u_a (
    .clk_dut(clk), .reset_dut(rst), .i_en(en), .i_mode(mode),
    .i_rand_a(ra), .i_rand_b(rb), .i_dir_a(da), .i_dir_b(db),
    .o_drive_a(a_drv_a), .o_drive_b(a_drv_b), .o_drive_valid(a_drv_v),
    .o_drive_delayed_a(a_del_a), .o_drive_delayed_b(a_del_b), .o_delayed_valid(a_del_v),
`ifdef DRIVER_PARITY_EN
    .o_delayed_parity(a_del_p),
`endif
    .o_vec_count(a_cnt)
  );

  driver_pipe #(.WIDTH(W), .LATENCY(LB), .CNT_W(CB)) u_b (
    .clk_dut(clk), .reset_dut(rst), .i_en(en), .i_mode(mode),
    .i_rand_a(ra), .i_rand_b(rb), .i_dir_a(da), .i_dir_b(db),
    .o_drive_a(b_drv_a), .o_drive_b(b_drv_b), .o_drive_valid(b_drv_v),
    .o_drive_delayed_a(b_del_a), .o_drive_delayed_b(b_del_b), .o_delayed_valid(b_del_v),
`ifdef DRIVER_PARITY_EN
    .o_delayed_parity(b_del_p),
`endif
    .o_vec_count(b_cnt)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         v;
    logic         p;
  } ent_t;

  ent_t         hist_a[$];
  ent_t         hist_b[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           sweep_pos = 0;
  logic [W-1:0] held_a = '0;
  logic [W-1:0] held_b = '0;
  int           cnt_a = 0;
  int           cnt_b = 0;
  bit           known = 0;

  function automatic logic [W-1:0] corner(input int k);
    logic [W-1:0] one;
    one = 1;
    case (k)
      0:       return '0;
      1:       return one;
      2:       return '1;
      default: return one << (W-1);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    hist_a.delete();
    hist_b.delete();
    repeat (LA) hist_a.push_back('0);
    repeat (LB) hist_b.push_back('0);
  endtask

  task automatic do_cycle(input logic r, input logic e, input logic [1:0] m,
                          input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] ya, input logic [W-1:0] yb);
    logic [W-1:0] ea, eb;
    logic         ev;
    int           pos;
    ent_t         ent;
    rst = r; en = e; mode = m; ra = xa; rb = xb; da = ya; db = yb;
    #1;
    pos = r ? 0 : sweep_pos;
    case (m)
      2'd0: begin ea = xa; eb = xb; end
      2'd1: begin ea = ya; eb = yb; end
      2'd2: begin ea = corner(pos / 4); eb = corner(pos % 4); end
      default: begin ea = r ? '0 : held_a; eb = r ? '0 : held_b; end
    endcase
    ev = e & ~r;
    check("drive_a", 64'(a_drv_a), 64'(ea));
    check("drive_b", 64'(a_drv_b), 64'(eb));
    check("drive_valid", 64'(a_drv_v), 64'(ev));
    check("drive_a_l1", 64'(b_drv_a), 64'(ea));
    check("drive_b_l1", 64'(b_drv_b), 64'(eb));
    if (known) begin
      check("del_a_l3", 64'(a_del_a), 64'(hist_a[0].a));
      check("del_b_l3", 64'(a_del_b), 64'(hist_a[0].b));
      check("del_v_l3", 64'(a_del_v), 64'(hist_a[0].v));
      check("del_a_l1", 64'(b_del_a), 64'(hist_b[0].a));
      check("del_b_l1", 64'(b_del_b), 64'(hist_b[0].b));
      check("del_v_l1", 64'(b_del_v), 64'(hist_b[0].v));
      check("count_c16", 64'(a_cnt), 64'(cnt_a));
      check("count_c4", 64'(b_cnt), 64'(cnt_b));
`ifdef DRIVER_PARITY_EN
      check("del_p_l3", 64'(a_del_p), 64'(hist_a[0].p));
      check("del_p_l1", 64'(b_del_p), 64'(hist_b[0].p));
`endif
    end
    @(posedge clk);
    if (r) begin
      flush_model();
      sweep_pos = 0;
      held_a = '0;
      held_b = '0;
      cnt_a = 0;
      cnt_b = 0;
      known = 1;
    end else begin
      ent = '{a: ea, b: eb, v: ev, p: ^{ea, eb}};
      hist_a.push_back(ent);
      void'(hist_a.pop_front());
      hist_b.push_back(ent);
      void'(hist_b.pop_front());
      if (m == 2'd2) begin
        if (e) sweep_pos = (sweep_pos + 1) % 16;
      end else begin
        sweep_pos = 0;
      end
      if (e && m != 2'd3) begin
        held_a = ea;
        held_b = eb;
      end
      if (e) begin
        if (cnt_a < (1 << CA) - 1) cnt_a++;
        if (cnt_b < (1 << CB) - 1) cnt_b++;
      end
    end
    #1;
    $display("cyc=%0d rst=%0b en=%0b mode=%0d drive=%h/%h", cyc, r, e, m, ea, eb);
    cyc++;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; ra = '0; rb = '0; da = '0; db = '0;
    flush_model();
    #2;
    // Reset two cycles, then random vectors with the 3-cycle delay line filling.
    repeat (2) do_cycle(1, 1, 2'd0, rnd(), rnd(), rnd(), rnd());
    repeat (6) do_cycle(0, 1, 2'd0, rnd(), rnd(), rnd(), rnd());

    // Directed pair then a few random directed vectors.
    do_cycle(0, 1, 2'd1, rnd(), rnd(), 32'h0000_0005, 32'hFFFF_FFFF);
    check("dir_del_a_l1", 64'(b_del_a), 64'h5);
    check("dir_del_b_l1", 64'(b_del_b), 64'hFFFF_FFFF);
    check("dir_del_v_l1", 64'(b_del_v), 64'h1);
    repeat (4) do_cycle(0, 1, 2'd1, rnd(), rnd(), rnd(), rnd());

    // Full corner sweep from a fresh reset, wrapping once.
    do_cycle(1, 1, 2'd2, rnd(), rnd(), rnd(), rnd());
    repeat (17) do_cycle(0, 1, 2'd2, rnd(), rnd(), rnd(), rnd());
    check("sweep_count", 64'(a_cnt), 64'd17);

    // Stall then hold the last driven pair.
    do_cycle(0, 1, 2'd0, 32'h1234, 32'h5678, rnd(), rnd());
    repeat (2) do_cycle(0, 0, 2'd0, rnd(), rnd(), rnd(), rnd());
    do_cycle(0, 1, 2'd3, rnd(), rnd(), rnd(), rnd());
    check("hold_a", 64'(a_drv_a), 64'h1234);
    check("hold_b", 64'(a_drv_b), 64'h5678);
    repeat (3) do_cycle(0, 1, 2'd3, rnd(), rnd(), rnd(), rnd());

    // Counter saturation on the 4-bit instance.
    do_cycle(1, 0, 2'd0, rnd(), rnd(), rnd(), rnd());
    repeat (20) do_cycle(0, 1, 2'd0, rnd(), rnd(), rnd(), rnd());
    check("sat_count_c4", 64'(b_cnt), 64'd15);
    check("sat_count_c16", 64'(a_cnt), 64'd20);

    // Reset in the middle of a sweep, then restart the sweep and parity probe.
    do_cycle(0, 1, 2'd1, rnd(), rnd(), rnd(), rnd());
    repeat (7) do_cycle(0, 1, 2'd2, rnd(), rnd(), rnd(), rnd());
    do_cycle(1, 1, 2'd2, rnd(), rnd(), rnd(), rnd());
    check("flush_del_v_l3", 64'(a_del_v), 64'h0);
    check("flush_del_a_l3", 64'(a_del_a), 64'h0);
    repeat (4) do_cycle(0, 1, 2'd2, rnd(), rnd(), rnd(), rnd());
    do_cycle(0, 1, 2'd1, rnd(), rnd(), 32'h1, 32'h0);
`ifdef DRIVER_PARITY_EN
    check("parity_l1", 64'(b_del_p), 64'h1);
`endif
    check("probe_del_a_l1", 64'(b_del_a), 64'h1);

    // Random soak including occasional resets and stalls.
    for (int i = 0; i < 300; i++)
      do_cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)), rnd(), rnd(), rnd(), rnd());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
